fpga_result_display: RTL and testbench
======================================

Name: fpga_result_display

Overview:
- Parametrised board-level debug/display block that sits between the board I/O (buttons, switches, LEDs) and the processor's register-file debug read port.
- Generates a clean processor reset (asynchronous assert, synchronous deassert).
- Debounces two navigation buttons and steps a register-address pointer, either manually or by timed auto-scroll.
- Snapshots the addressed register and shows a switch-selected LED_W-bit page of it on the LEDs.

Parameters:
- DATA_W, 32, width of register value.
- LED_W, 16, LED count; DATA_W must be a multiple of LED_W.
- NUM_REGS, 16, number of addressable registers (power of 2); REG_AW = clog2(NUM_REGS).
- PAGE_W, clog2(DATA_W/LED_W) (min 1), width of page-select switches.
- DEBOUNCE_CYCLES, 1000000, stable-input cycles required to accept a button level.
- SCROLL_CYCLES, 100000000, auto-scroll dwell per register, in clk cycles.
- RESET_ADDR, 2, pointer value after reset.

Ports:
- clk  in  1  system clock (100 MHz on board).
- reset_n  in  1  asynchronous active-low reset.
- btn_next  in  1  raw, asynchronous button; advances the pointer.
- btn_prev  in  1  raw, asynchronous button; decrements the pointer.
- sw_auto  in  1  raw switch; 1 = auto-scroll enabled.
- sw_page  in  PAGE_W  raw switches; LED page select (0 = bits [LED_W-1:0]).
- cpu_reset_n  out  1  synchronised reset for the processor.
- reg_addr  out  REG_AW  register-file debug read address.
- reg_data  in  DATA_W  combinational read data for reg_addr.
- leds  out  LED_W  displayed page.
- chg_flag  out  1  value-changed indicator (see Optional Feature).

Behaviour:
- Reset sync:
  - cpu_reset_n drops to 0 asynchronously with reset_n low.
  - After reset_n rises, cpu_reset_n deasserts on the 2nd rising clk edge (2-flop chain).
- Reset values: reg_addr=RESET_ADDR, leds=0, chg_flag=0, snapshot=0, scroll timer=0, debouncer state=released, cpu_reset_n=0. Reset mid-operation aborts all counters immediately.
- Inputs: all raw inputs (buttons, sw_auto, sw_page) pass through 2-flop synchronisers before use.
- Debouncer, per button:
  - Counter restarts whenever the synchronised input differs from the accepted level.
  - When the counter reaches DEBOUNCE_CYCLES-1, the new level is accepted.
  - A released->pressed acceptance emits exactly one 1-cycle step pulse.
  - Release emits no pulse; holding a button gives exactly one step.
- Pointer:
  - next pulse: reg_addr+1, wraps NUM_REGS-1 -> 0.
  - prev pulse: reg_addr-1, wraps 0 -> NUM_REGS-1.
  - next and prev in the same cycle: no change.
- Auto-scroll:
  - While synchronised sw_auto=1, the timer counts 0..SCROLL_CYCLES-1; at terminal count the pointer does +1 (wrapping) and the timer returns to 0.
  - Any manual step pulse takes priority and clears the timer.
  - sw_auto=0 holds the timer at 0.
- Snapshot: registered every cycle, snapshot <= reg_data. The LEDs reflect a new reg_addr 1 cycle after the pointer changes.
- LEDs: leds = snapshot[page*LED_W +: LED_W], registered, so total latency is addr change -> 2 clk. A page index >= DATA_W/LED_W shows all zeros.
- No handshake with the processor; reg_data is assumed valid in the cycle reg_addr is presented.

Optional Feature:
- Macro FPGA_DISP_CHANGE_FLAG_EN.
- Defined:
  - chg_flag sets (sticky) when the snapshot changes value while reg_addr is unchanged from the previous cycle.
  - chg_flag clears on any pointer change or reset.
  - A pointer change and a data change in the same cycle leave the flag cleared.
- Undefined: chg_flag tied to 0, and the comparison logic and previous-snapshot register are absent.

Decomposition:
- Package fpga_disp_pkg:
  - Default constants for DEBOUNCE_CYCLES, SCROLL_CYCLES and RESET_ADDR.
  - A clog2 helper function.
  - Page-count derivation (DATA_W/LED_W).
- Sub-module button_debouncer:
  - Parameter CYCLES; ports clk, reset_n, raw, step_pulse.
  - Contains its own 2-flop synchroniser.
  - Instantiated twice.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, SCROLL_CYCLES=10, NUM_REGS=16, reg_data = {16'hA5A5, 12'h0, reg_addr}):
- Reset: assert reset_n=0 mid-run -> reg_addr=2, leds=0, cpu_reset_n=0 in the same cycle; release -> cpu_reset_n=1 exactly 2 edges later.
- Debounce: btn_next glitches of 1-3 cycles -> no step; then held 20 cycles -> exactly one step, reg_addr 2->3, leds=16'h0003 two cycles after the step.
- Wrap and simultaneous press: at reg_addr=15 press next -> 0; press prev -> 15; both pressed on the same edge -> reg_addr unchanged.
- Paging: sw_page=1 -> leds=16'hA5A5; sw_page=0 -> low half; with DATA_W=48, sw_page=3 -> leds=0.
- Auto-scroll: sw_auto=1 -> reg_addr increments every 10 cycles; a manual next at timer=6 -> immediate +1 and the next auto step 10 cycles later.
- FPGA_DISP_CHANGE_FLAG_EN: change reg_data at a fixed addr -> chg_flag=1 and stays 1; press next -> chg_flag=0. Built without the macro -> chg_flag stays 0 throughout.

Source files
------------

// File: rtl/fpga_disp_pkg.sv
// rtl/fpga_disp_pkg.sv - shared defaults and width helpers for the result display block
package fpga_disp_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_SCROLL_CYCLES   = 100000000;
  localparam int DEF_RESET_ADDR      = 2;

  // Never returns less than 1 so single-value ranges still get a real vector.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int page_count(input int data_w, input int led_w);
    return data_w / led_w;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronised, debounced button with one step pulse per press
module button_debouncer
  import fpga_disp_pkg::*;
#(
  parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic step_pulse
);

  localparam int CW = clog2(CYCLES);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count only while the input disagrees with the accepted level; agreement restarts it.
  always_comb begin
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(CYCLES - 1)) begin
        level_d = sync_q[1];
        pulse_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign step_pulse = pulse_q;

endmodule

// File: rtl/fpga_result_display.sv
// rtl/fpga_result_display.sv - board debug display: reset sync, register pointer, paged LED view
// Optional value-changed flag enabled by FPGA_DISP_CHANGE_FLAG_EN.
module fpga_result_display
  import fpga_disp_pkg::*;
#(
  parameter  int DATA_W          = 32,
  parameter  int LED_W           = 16,
  parameter  int NUM_REGS        = 16,
  parameter  int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter  int SCROLL_CYCLES   = DEF_SCROLL_CYCLES,
  parameter  int RESET_ADDR      = DEF_RESET_ADDR,
  localparam int REG_AW          = clog2(NUM_REGS),
  localparam int PAGES           = page_count(DATA_W, LED_W),
  localparam int PAGE_W          = clog2(PAGES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              sw_auto,
  input  logic [PAGE_W-1:0] sw_page,
  output logic              cpu_reset_n,
  output logic [REG_AW-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data,
  output logic [LED_W-1:0]  leds,
  output logic              chg_flag
);

  localparam int TW = clog2(SCROLL_CYCLES);

  logic [1:0]        rst_q;
  logic [1:0]        auto_q;
  logic [PAGE_W-1:0] page_s1_q, page_q;
  logic              next_p, prev_p;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] snap_q;
  logic [LED_W-1:0]  leds_q, leds_d;

  button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .reset_n(reset_n), .raw(btn_next), .step_pulse(next_p)
  );
  button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk(clk), .reset_n(reset_n), .raw(btn_prev), .step_pulse(prev_p)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_q     <= '0;
      auto_q    <= '0;
      page_s1_q <= '0;
      page_q    <= '0;
      addr_q    <= REG_AW'(RESET_ADDR);
      timer_q   <= '0;
      snap_q    <= '0;
      leds_q    <= '0;
    end else begin
      rst_q     <= {rst_q[0], 1'b1};
      auto_q    <= {auto_q[0], sw_auto};
      page_s1_q <= sw_page;
      page_q    <= page_s1_q;
      addr_q    <= addr_d;
      timer_q   <= timer_d;
      snap_q    <= reg_data;
      leds_q    <= leds_d;
    end
  end

  // Manual pulses outrank auto-scroll; opposing pulses cancel but still restart the dwell.
  always_comb begin
    addr_d  = addr_q;
    timer_d = timer_q;
    if (next_p || prev_p) begin
      timer_d = '0;
      if (next_p && !prev_p)      addr_d = addr_q + 1'b1;
      else if (prev_p && !next_p) addr_d = addr_q - 1'b1;
    end else if (!auto_q[1]) begin
      timer_d = '0;
    end else if (timer_q == TW'(SCROLL_CYCLES - 1)) begin
      timer_d = '0;
      addr_d  = addr_q + 1'b1;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Unlisted page indices fall through to zero.
  always_comb begin
    leds_d = '0;
    for (int p = 0; p < PAGES; p++) begin
      if (page_q == PAGE_W'(p)) leds_d = snap_q[p*LED_W +: LED_W];
    end
  end

`ifdef FPGA_DISP_CHANGE_FLAG_EN
  logic [REG_AW-1:0] addr_prev_q;
  logic              chg_q, chg_d;

  always_comb begin
    chg_d = chg_q;
    if (addr_q != addr_prev_q)  chg_d = 1'b0;
    else if (reg_data != snap_q) chg_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_prev_q <= REG_AW'(RESET_ADDR);
      chg_q       <= 1'b0;
    end else begin
      addr_prev_q <= addr_q;
      chg_q       <= chg_d;
    end
  end

  assign chg_flag = chg_q;
`else
  assign chg_flag = 1'b0;
`endif

  assign cpu_reset_n = rst_q[1];
  assign reg_addr    = addr_q;
  assign leds        = leds_q;

endmodule

// File: tb/tb_fpga_result_display.sv
// tb/tb_fpga_result_display.sv - self-checking bench for fpga_result_display
module tb_fpga_result_display;

`ifdef FPGA_DISP_CHANGE_FLAG_EN
  localparam logic EXP_FLAG = 1'b1;
`else
  localparam logic EXP_FLAG = 1'b0;
`endif

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        btn_next = 1'b0, btn_prev = 1'b0, sw_auto = 1'b0;
  logic        sw_page = 1'b0;
  logic [1:0]  sw_page48 = 2'd0;
  logic [31:0] data_mod = '0;

  logic        cpu_reset_n, chg_flag, cpu_reset_n48, chg_flag48;
  logic [3:0]  reg_addr, reg_addr48;
  logic [31:0] reg_data;
  logic [47:0] reg_data48;
  logic [15:0] leds, leds48;

  int errors = 0, checks = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign reg_data   = {16'hA5A5, 12'h0, reg_addr} ^ data_mod;
  assign reg_data48 = {16'hBEEF, 16'hA5A5, 12'h0, reg_addr48};

  fpga_result_display #(.DEBOUNCE_CYCLES(4), .SCROLL_CYCLES(10), .NUM_REGS(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .btn_next(btn_next), .btn_prev(btn_prev),
    .sw_auto(sw_auto), .sw_page(sw_page), .cpu_reset_n(cpu_reset_n),
    .reg_addr(reg_addr), .reg_data(reg_data), .leds(leds), .chg_flag(chg_flag)
  );

  fpga_result_display #(.DATA_W(48), .DEBOUNCE_CYCLES(4), .SCROLL_CYCLES(10)) u_dut48 (
    .clk(clk), .reset_n(reset_n), .btn_next(btn_next), .btn_prev(btn_prev),
    .sw_auto(sw_auto), .sw_page(sw_page48), .cpu_reset_n(cpu_reset_n48),
    .reg_addr(reg_addr48), .reg_data(reg_data48), .leds(leds48), .chg_flag(chg_flag48)
  );

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic nx, input logic pv, input int hold);
    @(negedge clk);
    btn_next = nx;
    btn_prev = pv;
    repeat (hold) @(negedge clk);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_change(input int budget, output int t, output logic ok);
    logic [3:0] old;
    old = reg_addr;
    ok  = 1'b0;
    t   = cyc;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (reg_addr != old) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
  endtask

  typedef struct {
    logic       nx;
    logic       pv;
    logic [3:0] exp_addr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int model_addr, changes, tstep, t0, t1, tm, t2, op;
    logic [3:0] prev_addr, a0;
    logic ok;

    tbl[0] = '{1'b0, 1'b1, 4'd2};
    tbl[1] = '{1'b0, 1'b1, 4'd1};
    tbl[2] = '{1'b0, 1'b1, 4'd0};
    tbl[3] = '{1'b0, 1'b1, 4'd15};
    tbl[4] = '{1'b1, 1'b0, 4'd0};
    tbl[5] = '{1'b0, 1'b1, 4'd15};
    tbl[6] = '{1'b1, 1'b1, 4'd15};
    tbl[7] = '{1'b1, 1'b0, 4'd0};
    tbl[8] = '{1'b1, 1'b1, 4'd0};

    // Power-on reset and synchronous release
    repeat (3) @(negedge clk);
    check("rst_addr", reg_addr, 4'd2);
    check("rst_leds", leds, 16'h0);
    check("rst_cpu", cpu_reset_n, 1'b0);
    check("rst_flag", chg_flag, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rel_edge1", cpu_reset_n, 1'b0);
    @(posedge clk); #1;
    check("rel_edge2", cpu_reset_n, 1'b1);
    repeat (4) @(negedge clk);
    check("leds_init", leds, 16'h0002);

    // Glitches shorter than the debounce window are ignored
    for (int k = 1; k <= 3; k++) begin
      press(1'b1, 1'b0, k);
      check("glitch_addr", reg_addr, 4'd2);
    end

    // Long hold gives exactly one step; LEDs follow two edges later
    @(negedge clk);
    btn_next  = 1'b1;
    changes   = 0;
    tstep     = -1;
    prev_addr = reg_addr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (reg_addr != prev_addr) begin
        changes++;
        prev_addr = reg_addr;
        if (tstep < 0) tstep = cyc;
      end
      if (tstep >= 0 && cyc == tstep + 1) check("leds_lat1", leds, 16'h0002);
      if (tstep >= 0 && cyc == tstep + 2) check("leds_lat2", leds, 16'h0003);
    end
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    check("hold_steps", changes, 1);
    check("hold_addr", reg_addr, 4'd3);

    // Wrap-around and simultaneous presses
    foreach (tbl[i]) begin
      press(tbl[i].nx, tbl[i].pv, 12);
      check("tbl_addr", reg_addr, tbl[i].exp_addr);
      check("tbl_leds", leds, {12'h0, tbl[i].exp_addr});
      check("tbl_flag", chg_flag, 1'b0);
    end
    model_addr = 0;

    // Paging, including an out-of-range page on the 48-bit instance
    @(negedge clk); sw_page = 1'b1; sw_page48 = 2'd2;
    repeat (6) @(negedge clk);
    check("page1", leds, 16'hA5A5);
    check("page48_2", leds48, 16'hBEEF);
    sw_page48 = 2'd3;
    repeat (6) @(negedge clk);
    check("page48_3", leds48, 16'h0);
    sw_page = 1'b0; sw_page48 = 2'd0;
    repeat (6) @(negedge clk);
    check("page0", leds, 16'h0000);
    check("page48_0", leds48, 16'h0000);

    // Randomized presses, glitches and page flips against an arithmetic model
    for (int n = 0; n < 30; n++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0: begin press(1'b1, 1'b0, 12); model_addr = (model_addr + 1) % 16; end
        1: begin press(1'b0, 1'b1, 12); model_addr = (model_addr + 15) % 16; end
        2: press(1'b1, 1'b1, 12);
        3: press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
        default: begin
          @(negedge clk); sw_page = ~sw_page;
          repeat (6) @(negedge clk);
        end
      endcase
      check("rnd_addr", reg_addr, 4'(model_addr));
      check("rnd_leds", leds, sw_page ? 16'hA5A5 : {12'h0, 4'(model_addr)});
      check("rnd_flag", chg_flag, 1'b0);
    end

    // Auto-scroll dwell and manual override
    @(negedge clk); sw_page = 1'b0; sw_auto = 1'b1;
    a0 = reg_addr;
    wait_change(40, t0, ok);
    check("auto_first_ok", ok, 1'b1);
    check("auto_first_addr", reg_addr, a0 + 4'd1);
    wait_change(15, t1, ok);
    check("auto_second_ok", ok, 1'b1);
    check("auto_period", t1 - t0, 10);
    check("auto_second_addr", reg_addr, a0 + 4'd2);
    btn_next = 1'b1;
    wait_change(15, tm, ok);
    check("manual_ok", ok, 1'b1);
    check("manual_at_timer6", tm - t1, 7);
    check("manual_addr", reg_addr, a0 + 4'd3);
    btn_next = 1'b0;
    wait_change(15, t2, ok);
    check("after_manual_ok", ok, 1'b1);
    check("after_manual_period", t2 - tm, 10);
    check("after_manual_addr", reg_addr, a0 + 4'd4);
    sw_auto = 1'b0;
    repeat (5) @(negedge clk);
    a0 = reg_addr;
    repeat (25) @(negedge clk);
    check("auto_off_hold", reg_addr, a0);

    // Value-changed flag
    check("flag_pre", chg_flag, 1'b0);
    data_mod = 32'h0000_0100;
    repeat (4) @(negedge clk);
    check("flag_set", chg_flag, EXP_FLAG);
    repeat (10) @(negedge clk);
    check("flag_sticky", chg_flag, EXP_FLAG);
    press(1'b1, 1'b0, 12);
    check("flag_clear", chg_flag, 1'b0);
    data_mod = '0;

    // Reset mid-operation, with a press in flight
    @(negedge clk); sw_page = 1'b1; btn_next = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_addr", reg_addr, 4'd2);
    check("mid_rst_leds", leds, 16'h0);
    check("mid_rst_cpu", cpu_reset_n, 1'b0);
    check("mid_rst_flag", chg_flag, 1'b0);
    btn_next = 1'b0; sw_page = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_edge1", cpu_reset_n, 1'b0);
    @(posedge clk); #1;
    check("mid_rel_edge2", cpu_reset_n, 1'b1);
    repeat (12) @(negedge clk);
    check("mid_rel_addr", reg_addr, 4'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
